// File: rtl/msk_sharing_unit.sv
// Splits an unmasked block and key into d Boolean shares: masks are filled from a 32-bit random stream, NW words per block.
// The output appears NW accepted words after input accept and is held until out_ready; in_valid and rnd_valid are ignored outside their phases.
module msk_sharing_unit #(
   parameter int d     = 2,
   parameter int RND_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [127:0]       in_data,
   input  logic [255:0]       in_key,
   input  logic               rnd_valid,
   output logic               rnd_ready,
   input  logic [RND_W-1:0]   rnd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [128*d-1:0]   sh_data,
   output logic [256*d-1:0]   sh_key
);
   localparam int NW = (d - 1) * 12;
   localparam int MW = (d - 1) * 384;
   localparam int CW = $clog2(NW + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [127:0]        val_data;
   logic [255:0]        val_key;
   logic [MW-1:0]       m;
   logic [127:0]        rev_data;
   logic [255:0]        rev_key;
   logic [d-1:0][127:0] dsh;
   logic [d-1:0][255:0] ksh;

   // Byte 0 arrives in the top byte and must land in bits [7:0].
   always_comb begin
      rev_data = '0;
      rev_key  = '0;
      for (int b = 0; b < 16; b++) rev_data[8*b +: 8] = in_data[8*(15-b) +: 8];
      for (int b = 0; b < 32; b++) rev_key[8*b +: 8]  = in_key[8*(31-b) +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         val_data  <= '0;
         val_key   <= '0;
         m         <= '0;
         in_ready  <= 1'b1;
         rnd_ready <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  val_data  <= rev_data;
                  val_key   <= rev_key;
                  cnt       <= '0;
                  state     <= COLLECT;
                  in_ready  <= 1'b0;
                  rnd_ready <= 1'b1;
               end
            end
            COLLECT: begin
               if (rnd_valid) begin
                  m[RND_W*int'(cnt) +: RND_W] <= rnd_data;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(NW - 1)) begin
                     state     <= OUT;
                     rnd_ready <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            OUT: begin
               // Wipe secrets as soon as the shares have left.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  val_data  <= '0;
                  val_key   <= '0;
                  m         <= '0;
                  cnt       <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               val_data  <= '0;
               val_key   <= '0;
               m         <= '0;
               in_ready  <= 1'b1;
               rnd_ready <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      dsh    = '0;
      ksh    = '0;
      dsh[0] = val_data;
      ksh[0] = val_key;
      for (int j = 1; j < d; j++) begin
         dsh[j] = m[(j-1)*128 +: 128];
         ksh[j] = m[(d-1)*128 + (j-1)*256 +: 256];
         dsh[0] = dsh[0] ^ dsh[j];
         ksh[0] = ksh[0] ^ ksh[j];
      end
   end

   // Shares of one bit sit side by side on the bus.
   always_comb begin
      sh_data = '0;
      sh_key  = '0;
      if (out_valid) begin
         for (int i = 0; i < 128; i++)
            for (int j = 0; j < d; j++) sh_data[i*d+j] = dsh[j][i];
         for (int i = 0; i < 256; i++)
            for (int j = 0; j < d; j++) sh_key[i*d+j] = ksh[j][i];
      end
   end

endmodule

// File: doc/msk_sharing_unit.md
MSK_SHARING_UNIT -- requirements
Module: msk_sharing_unit

Interface
REQ-001 SHALL have parameter d, default 2, number of shares (d >= 2).
REQ-002 SHALL have parameter RND_W, fixed at 32, randomness word width.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, unmasked input offered.
REQ-006 SHALL have port in_ready, output, 1, unit accepts input.
REQ-007 SHALL have port in_data, input, 128, unmasked data block; byte 0 in [127:120].
REQ-008 SHALL have port in_key, input, 256, unmasked key; byte 0 in [255:248]; 128-bit keys occupy [255:128] with [127:0] zero.
REQ-009 SHALL have port rnd_valid, input, 1, randomness word offered.
REQ-010 SHALL have port rnd_ready, output, 1, unit consumes randomness word.
REQ-011 SHALL have port rnd_data, input, 32, randomness word.
REQ-012 SHALL have port out_valid, output, 1, shared block available.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts shared block.
REQ-014 SHALL have port sh_data, output, 128*d, shared data in shbus encoding.
REQ-015 SHALL have port sh_key, output, 256*d, shared key in shbus encoding.

Function
REQ-016 SHALL byte-reverse in_data and in_key on capture: byte 0 maps to bits [7:0] of the share-0 value.
REQ-017 SHALL build shares as follows: shares 1..d-1 are random masks; share 0 = byte-reversed value XOR all masks.
REQ-018 SHALL use shbus encoding on output: sh_data[i*d+j] = share j of data bit i (same rule for sh_key with 256 bits).
REQ-019 SHALL need NW = (d-1)*12 randomness words per block, held in mask vector M of width (d-1)*384.
REQ-020 SHALL write rnd word k (k = 0..NW-1, arrival order) into M[32k +: 32].
REQ-021 SHALL map M as follows: data mask j = M[(j-1)*128 +: 128]; key mask j = M[(d-1)*128 + (j-1)*256 +: 256].
REQ-022 SHALL implement FSM states IDLE, COLLECT and OUT.
REQ-023 SHALL behave as follows in IDLE: in_ready=1, rnd_ready=0, out_valid=0; on in_valid&in_ready, capture inputs, clear word counter, go to COLLECT.
REQ-024 SHALL behave as follows in COLLECT: rnd_ready=1, in_ready=0; each rnd_valid cycle stores one word and increments the counter; the cycle storing word NW-1 goes to OUT; rnd_valid low stalls with no state change.
REQ-025 SHALL behave as follows in OUT: out_valid=1, sh_data and sh_key stable, rnd_ready=0, in_ready=0; on out_ready go to IDLE.
REQ-026 SHALL give latency as follows: input accepted at edge t; with continuous randomness, out_valid high from cycle t+NW (12 cycles for d=2).
REQ-027 SHALL zero the captured value and M on the edge the output is accepted (no residual secrets).
REQ-028 SHALL drive sh_data and sh_key to zero whenever out_valid=0.
REQ-029 SHALL ignore in_valid outside IDLE and rnd_valid outside COLLECT; neither alters state.
REQ-030 SHALL size the word counter to ceil(log2(NW+1)) bits; it never wraps, since it is cleared on entry to COLLECT.
REQ-031 SHALL never accept a new block while one is held or pending output.

Reset
REQ-032 SHALL, while rst=1 at a rising edge: FSM goes to IDLE; counter, captured value and M are zeroed; outputs in_ready=1 (after reset), rnd_ready=0, out_valid=0, sh_data=0, sh_key=0.
REQ-033 SHALL, on reset in COLLECT or OUT, discard the pending block; no output for it is ever produced.

Verification
REQ-034 SHALL cover zero masks: d=2, in_data=00112233445566778899aabbccddeeff, rnd all 0 -> share0 of data = ffeeddccbbaa99887766554433221100, share1 = 0; out_valid at cycle t+12.
REQ-035 SHALL cover all-one masks: d=2, same data, rnd=ffffffff -> share1 all ones; share0 = 0011..ff byte-reversed, inverted; recombined XOR = ffeeddcc...1100.
REQ-036 SHALL cover random use: d=3, 200 blocks, random rnd, random rnd_valid gaps and out_ready back-pressure -> recombined data/key equal byte-reversed inputs; each block consumes exactly 24 words; output stable while stalled.
REQ-037 SHALL cover reset mid-operation: rst asserted after 5 words in COLLECT -> next cycle in IDLE, out_valid=0; next block needs a full 12 fresh words.
REQ-038 SHALL cover 128-bit key: in_key=000102030405060708090a0b0c0d0e0f followed by 128 zero bits -> recombined key[127:0] = 0f0e0d0c0b0a09080706050403020100, key[255:128]=0.
REQ-039 SHALL cover the end-to-end path: unit feeding MSKaes_32bits_core, FIPS-197 key 000102..0f, plaintext 00112233..ff -> recombined core output 69c4e0d86a7b0430d8cdb78070b4c55a (byte order per core convention).
